// File: rtl/ysyx_22050854_fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package ysyx_22050854_fetch_pkg;

   localparam int          INST_W           = 32;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

   // Fetch sequencer phases: issue request, await response, present IF/ID slot.
   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_OUT  = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/ysyx_22050854_evt_cnt.sv
// Wrapping event counter with asynchronous active-high reset.
module ysyx_22050854_evt_cnt #(
   parameter int W = 32
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   // Next count: add one on each event, wrapping silently.
   always_comb begin
      count_d = count_q;
      if (inc) begin
         count_d = count_q + {{(W-1){1'b0}}, 1'b1};
      end
   end

   // Count register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/ysyx_22050854_fetch_ctrl.sv
// Instruction-fetch sequencer: one outstanding imem request at a time,
// IF/ID output slot, redirect handling with wrong-path response squashing.
module ysyx_22050854_fetch_ctrl
   import ysyx_22050854_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              redirect_valid,
   input  logic [31:0]       redirect_pc,
   input  logic              id_ready,
   output logic              imem_req_valid,
   output logic [31:0]       imem_req_addr,
   input  logic              imem_req_ready,
   input  logic              imem_resp_valid,
   input  logic [INST_W-1:0] imem_resp_data,
   output logic              if_valid,
   output logic [31:0]       if_pc,
   output logic [INST_W-1:0] if_inst,
   output logic [31:0]       fetch_pc,
   output logic [31:0]       fetch_cnt,
   output logic [31:0]       kill_cnt
);

   fetch_state_e      state_q, state_d;
   logic [31:0]       fetch_pc_q, fetch_pc_d;
   logic              kill_q, kill_d;
   logic              if_valid_q, if_valid_d;
   logic [31:0]       if_pc_q, if_pc_d;
   logic [INST_W-1:0] if_inst_q, if_inst_d;
   logic              fetch_inc;
   logic              kill_inc;
   logic              req_fire;

   // Request outputs decode only state and the fetch PC register.
   assign imem_req_valid = (state_q == S_REQ);
   assign imem_req_addr  = fetch_pc_q;
   assign req_fire       = imem_req_valid & imem_req_ready;

   // Next-state logic; a redirect overrides the fetch PC in every state.
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      kill_d     = kill_q;
      if_valid_d = if_valid_q;
      if_pc_d    = if_pc_q;
      if_inst_d  = if_inst_q;
      fetch_inc  = 1'b0;
      kill_inc   = 1'b0;
      case (state_q)
         S_REQ: begin
            if (req_fire) begin
               fetch_inc = 1'b1;
               state_d   = S_WAIT;
               // The request just accepted targets the old path.
               if (redirect_valid) begin
                  kill_d = 1'b1;
               end
            end
         end
         S_WAIT: begin
            if (imem_resp_valid) begin
               if (kill_q || redirect_valid) begin
                  kill_inc = 1'b1;
                  kill_d   = 1'b0;
                  state_d  = S_REQ;
               end else begin
                  if_inst_d  = imem_resp_data;
                  if_pc_d    = fetch_pc_q;
                  if_valid_d = 1'b1;
                  fetch_pc_d = fetch_pc_q + 32'd4;
                  state_d    = S_OUT;
               end
            end else if (redirect_valid) begin
               kill_d = 1'b1;
            end
         end
         S_OUT: begin
            // A redirect makes the held slot wrong-path, so drop it too.
            if (id_ready || redirect_valid) begin
               if_valid_d = 1'b0;
               state_d    = S_REQ;
            end
         end
         default: begin
            state_d    = S_REQ;
            if_valid_d = 1'b0;
         end
      endcase
      if (redirect_valid) begin
         fetch_pc_d = redirect_pc & ~32'd3;
      end
   end

   // Sequencer state and IF/ID slot registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= S_REQ;
         fetch_pc_q <= RESET_PC;
         kill_q     <= 1'b0;
         if_valid_q <= 1'b0;
         if_pc_q    <= '0;
         if_inst_q  <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         kill_q     <= kill_d;
         if_valid_q <= if_valid_d;
         if_pc_q    <= if_pc_d;
         if_inst_q  <= if_inst_d;
      end
   end

   ysyx_22050854_evt_cnt #(.W(32)) u_fetch_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (fetch_inc),
      .count (fetch_cnt)
   );

   ysyx_22050854_evt_cnt #(.W(32)) u_kill_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (kill_inc),
      .count (kill_cnt)
   );

   assign if_valid = if_valid_q;
   assign if_pc    = if_pc_q;
   assign if_inst  = if_inst_q;
   assign fetch_pc = fetch_pc_q;

endmodule

// File: tb/tb_ysyx_22050854_fetch_ctrl.sv
// Self-checking bench for the fetch sequencer: directed scenarios followed by
// randomized traffic, compared every cycle against a transaction-level model.
module tb_ysyx_22050854_fetch_ctrl;

   localparam logic [31:0] RST_PC = 32'h8000_0000;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        id_ready = 1'b0;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready = 1'b0;
   logic        imem_resp_valid = 1'b0;
   logic [31:0] imem_resp_data = '0;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_inst;
   logic [31:0] fetch_pc;
   logic [31:0] fetch_cnt;
   logic [31:0] kill_cnt;

   int checks = 0;
   int errors = 0;

   // Reference model: request outstanding / slot occupied / wrong-path flags.
   logic [31:0] m_pc;
   bit          m_outstanding;
   bit          m_wrong;
   bit          m_slot;
   logic [31:0] m_slot_pc;
   logic [31:0] m_slot_inst;
   logic [31:0] m_fetch;
   logic [31:0] m_kill;

   // Memory model: single outstanding request with a countdown latency.
   bit          mem_busy;
   int          mem_lat;
   logic [31:0] mem_data;

   ysyx_22050854_fetch_ctrl dut (
      .clock           (clock),
      .reset           (reset),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .id_ready        (id_ready),
      .imem_req_valid  (imem_req_valid),
      .imem_req_addr   (imem_req_addr),
      .imem_req_ready  (imem_req_ready),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .if_valid        (if_valid),
      .if_pc           (if_pc),
      .if_inst         (if_inst),
      .fetch_pc        (fetch_pc),
      .fetch_cnt       (fetch_cnt),
      .kill_cnt        (kill_cnt)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc          = RST_PC;
      m_outstanding = 0;
      m_wrong       = 0;
      m_slot        = 0;
      m_slot_pc     = '0;
      m_slot_inst   = '0;
      m_fetch       = '0;
      m_kill        = '0;
      mem_busy      = 0;
      mem_lat       = 0;
      mem_data      = '0;
   endtask

   task automatic check_outputs();
      chk("req_valid", {31'd0, imem_req_valid}, {31'd0, !m_outstanding && !m_slot});
      chk("req_addr",  imem_req_addr, m_pc);
      chk("if_valid",  {31'd0, if_valid}, {31'd0, m_slot});
      chk("if_pc",     if_pc, m_slot_pc);
      chk("if_inst",   if_inst, m_slot_inst);
      chk("fetch_pc",  fetch_pc, m_pc);
      chk("fetch_cnt", fetch_cnt, m_fetch);
      chk("kill_cnt",  kill_cnt, m_kill);
   endtask

   // One clock cycle: check at the negedge, drive inputs, advance the model.
   task automatic cycle(input bit rdy, input bit rv, input logic [31:0] rpc,
                        input bit idr, input int lat);
      bit exp_req;
      bit fire;
      bit resp;
      check_outputs();
      exp_req = !m_outstanding && !m_slot;
      resp    = mem_busy && (mem_lat == 0);
      imem_req_ready  = rdy;
      redirect_valid  = rv;
      redirect_pc     = rpc;
      id_ready        = idr;
      imem_resp_valid = resp;
      if (resp) imem_resp_data = mem_data;
      fire = exp_req && rdy;
      $display("cyc t=%0t rdy=%0b redir=%0b rpc=%h idr=%0b fire=%0b resp=%0b addr=%h",
               $time, rdy, rv, rpc, idr, fire, resp, imem_req_addr);
      if (m_slot) begin
         if (idr || rv) m_slot = 0;
      end else if (m_outstanding) begin
         if (resp) begin
            if (m_wrong || rv) begin
               m_kill  = m_kill + 1;
               m_wrong = 0;
            end else begin
               m_slot      = 1;
               m_slot_pc   = m_pc;
               m_slot_inst = mem_data;
               m_pc        = m_pc + 32'd4;
            end
            m_outstanding = 0;
         end else if (rv) begin
            m_wrong = 1;
         end
      end else if (fire) begin
         m_outstanding = 1;
         m_fetch       = m_fetch + 1;
         if (rv) m_wrong = 1;
      end
      if (rv) m_pc = rpc & ~32'd3;
      if (resp) mem_busy = 0;
      else if (mem_busy) mem_lat--;
      if (fire) begin
         mem_busy = 1;
         mem_lat  = lat - 1;
         mem_data = $urandom;
      end
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic do_reset();
      reset           = 1'b1;
      redirect_valid  = 1'b0;
      id_ready        = 1'b0;
      imem_req_ready  = 1'b0;
      imem_resp_valid = 1'b0;
      #1;
      model_reset();
      check_outputs();
      @(negedge clock);
      reset = 1'b0;
   endtask

   initial begin
      model_reset();
      @(negedge clock);
      do_reset();

      // Back-to-back fetches with 1-cycle memory and a ready decoder.
      for (int i = 0; i < 9; i++) cycle(1, 0, '0, 1, 1);
      chk("seq_fetch_cnt", fetch_cnt, 32'd3);
      chk("seq_last_pc", if_pc, RST_PC + 32'd8);

      // Decode stall: slot must hold for 5 cycles.
      cycle(1, 0, '0, 0, 1);
      cycle(0, 0, '0, 0, 1);
      for (int i = 0; i < 5; i++) cycle(1, 0, '0, 0, 1);
      chk("stall_valid", {31'd0, if_valid}, 32'd1);
      chk("stall_pc", if_pc, RST_PC + 32'd12);
      cycle(1, 0, '0, 1, 1);
      cycle(1, 0, '0, 1, 1);

      // Redirect while waiting; stale response arrives later and is dropped.
      do_reset();
      cycle(1, 0, '0, 1, 3);
      cycle(1, 1, 32'h8000_1002, 1, 1);
      cycle(1, 0, '0, 1, 1);
      cycle(1, 0, '0, 1, 1);
      chk("wait_kill_cnt", kill_cnt, 32'd1);
      chk("wait_if_valid", {31'd0, if_valid}, 32'd0);
      chk("wait_next_addr", imem_req_addr, 32'h8000_1000);
      chk("wait_req_valid", {31'd0, imem_req_valid}, 32'd1);

      // Redirect coincident with the request handshake.
      do_reset();
      cycle(1, 1, 32'h8000_2000, 1, 1);
      cycle(1, 0, '0, 1, 1);
      cycle(1, 0, '0, 1, 1);
      chk("coinc_fetch_cnt", fetch_cnt, 32'd2);
      chk("coinc_kill_cnt", kill_cnt, 32'd1);
      chk("coinc_addr_pc", fetch_pc, 32'h8000_2000);

      // Fetch PC wraps from the top of the address space.
      do_reset();
      cycle(0, 1, 32'hFFFF_FFFE, 1, 1);
      cycle(1, 0, '0, 0, 1);
      cycle(1, 0, '0, 0, 1);
      chk("wrap_fetch_pc", fetch_pc, 32'h0000_0000);
      chk("wrap_if_pc", if_pc, 32'hFFFF_FFFC);

      // Asynchronous reset while a request is outstanding.
      cycle(1, 0, '0, 1, 1);
      cycle(1, 0, '0, 1, 2);
      reset = 1'b1;
      #1;
      model_reset();
      chk("areset_fetch_cnt", fetch_cnt, 32'd0);
      chk("areset_if_valid", {31'd0, if_valid}, 32'd0);
      chk("areset_addr", imem_req_addr, RST_PC);
      check_outputs();
      @(negedge clock);
      reset = 1'b0;
      cycle(1, 0, '0, 1, 1);
      chk("areset_first_cnt", fetch_cnt, 32'd1);

      // Randomized traffic.
      for (int i = 0; i < 500; i++) begin
         logic [31:0] rpc;
         rpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
         cycle($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, rpc,
               $urandom_range(0, 9) < 7, int'($urandom_range(1, 3)));
      end
      check_outputs();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ysyx_22050854_fetch_ctrl.md
# ysyx_22050854_fetch_ctrl

Instruction-fetch sequencer between the PC/branch-resolution logic and the instruction memory port. Holds the architectural fetch PC and issues one fetch request at a time over a valid/ready handshake. Captures the returned instruction into an IF/ID output slot, applies redirects (jump, branch, ecall/mret) from decode, and squashes wrong-path responses. Two event counters support perf reporting in simulation.

## Interface
- RESET_PC, 32'h80000000, fetch PC loaded by reset
- clock  in  1  single clock, all state on posedge
- reset  in  1  asynchronous, active-high; clears all state immediately
- redirect_valid  in  1  decode resolved a taken jump/branch or CSR target this cycle
- redirect_pc  in  32  target PC; bits [1:0] ignored, forced to 0
- id_ready  in  1  decode accepts the IF/ID slot this cycle (low on data conflict or suspend)
- imem_req_valid  out  1  fetch request pending
- imem_req_addr  out  32  fetch address (= fetch_pc)
- imem_req_ready  in  1  memory accepts request
- imem_resp_valid  in  1  instruction returned (exactly one per accepted request)
- imem_resp_data  in  32  instruction word
- if_valid  out  1  IF/ID slot holds a valid instruction
- if_pc  out  32  PC of if_inst
- if_inst  out  32  instruction word
- fetch_pc  out  32  current fetch PC register
- fetch_cnt  out  32  accepted requests, wraps
- kill_cnt  out  32  squashed responses, wraps

## Operation
- States: S_REQ, S_WAIT, S_OUT. Reset: S_REQ, fetch_pc=RESET_PC, kill=0, if_valid=0, if_pc=0, if_inst=0, counters=0.
- S_REQ: imem_req_valid=1. Handshake (valid&ready) -> S_WAIT, fetch_cnt+1.
- S_WAIT: on imem_resp_valid: kill=1 -> discard, kill_cnt+1, kill<=0, -> S_REQ. Otherwise capture if_inst<=data, if_pc<=fetch_pc, fetch_pc<=fetch_pc+4, -> S_OUT.
- S_OUT: if_valid=1. id_ready -> S_REQ. Otherwise hold; all outputs stable.
- Redirect is highest priority. fetch_pc<=redirect_pc&~3 in every state.
  - In S_REQ without handshake: stay S_REQ. imem_req_addr may change while valid; the imem protocol permits this.
  - In S_REQ with same-cycle handshake: the request is counted, kill<=1, -> S_WAIT.
  - In S_WAIT without resp: kill<=1.
  - In S_WAIT with same-cycle resp: the response is discarded, kill_cnt+1, -> S_REQ.
  - In S_OUT: if_valid drops next cycle regardless of id_ready, -> S_REQ. The slot is wrong-path.
- Arithmetic: fetch_pc+4 modulo 2^32 (0xFFFFFFFC -> 0x00000000). Counters wrap silently.
- imem_resp_valid outside S_WAIT is a protocol error; it is ignored. The memory shares reset, so no response crosses a reset.

## Timing
- Min fetch latency: handshake in cycle T, response in T+1 -> if_valid in T+2 -> next request in T+3 if id_ready in T+2. Throughput ≤ 1 instruction per 3 cycles with 1-cycle memory.
- Redirect seen in cycle T -> imem_req_addr=target in T+1 (from S_REQ/S_OUT). From S_WAIT it follows the stale response by one cycle.
- All outputs registered except imem_req_valid/imem_req_addr, which decode state and fetch_pc only. There is no input->output combinational path.
- Reset asserted mid-transaction: state, kill and counters clear asynchronously. First request after deassertion is at RESET_PC in the next clock.

## Structure
- Package ysyx_22050854_fetch_pkg: state enum (S_REQ, S_WAIT, S_OUT), RESET_PC default, INST_W=32.
- One sub-module, ysyx_22050854_evt_cnt (32-bit wrapping counter with inc, async reset), instantiated twice. All other logic is flat.

## Test plan
- Reset release, memory ready=1, 1-cycle response, id_ready=1 -> addresses 0x80000000, 0x80000004, 0x80000008 in cycles 1, 4, 7; if_pc matches each; fetch_cnt=3.
- id_ready=0 for 5 cycles in S_OUT -> if_valid, if_pc, if_inst constant. Next request only after id_ready rises.
- Redirect to 0x80001002 while in S_WAIT, response 2 cycles later -> response dropped, if_valid never set for it, kill_cnt=1, next request addr 0x80001000.
- Redirect coincident with request handshake -> that response discarded; following request at target; fetch_cnt counts both.
- fetch_pc=0xFFFFFFFC, response returns -> fetch_pc=0x00000000, if_pc=0xFFFFFFFC.
- Reset asserted in S_WAIT between clock edges -> outputs cleared immediately; first post-reset request addr 0x80000000, counters 0.
